subleq_exec_unit: RTL and testbench
===================================

Name: subleq_exec_unit

Overview:
- Parametrised successor of the single-instruction execution unit; executes SUBLEQ programs: mem[B] <= mem[B] - mem[A]; branch to C if result <= 0, else pc+1.
- Acts as memory master: Harvard, separate instruction and data ports, both synchronous-read with 1-cycle latency.
- Adds run/step/stop control, self-loop halt detection and width generalisation; sits between the debug controller and the on-chip memories.

Parameters:
- ADDR_WIDTH, 16, width of instruction and data addresses, pc, and each A/B/C field.
- DATA_WIDTH, 32, data word width, two's complement.
- INSTR_WIDTH, 3*ADDR_WIDTH, instruction width; local, not overridable. Packed {A,B,C}, A in MSBs.

Ports:
- clk  in  1  clock, all logic on posedge.
- rst  in  1  synchronous reset, active-low (rst==0 resets).
- start  in  1  IDLE/HALT only: load start_pc, run continuously.
- step  in  1  IDLE only: execute one instruction from current pc.
- stop  in  1  request return to IDLE after current instruction.
- start_pc  in  ADDR_WIDTH  entry address, sampled with start.
- instr_rd  out  1  instruction read strobe.
- instr_addr  out  ADDR_WIDTH  instruction address.
- instr_rdata  in  INSTR_WIDTH  valid the cycle after instr_rd.
- data_rd  out  1  data read strobe.
- data_wr  out  1  data write strobe.
- data_addr  out  ADDR_WIDTH  data address.
- data_wdata  out  DATA_WIDTH  write data.
- data_rdata  in  DATA_WIDTH  valid the cycle after data_rd.
- busy  out  1  high in any state except IDLE and HALT.
- halted  out  1  high in HALT.
- pc  out  ADDR_WIDTH  current program counter.

Behaviour:
- Reset (rst==0 at posedge): state IDLE; pc, internal A/B/C/op/temp registers, stop_req and all outputs 0.
- States: IDLE, FETCH, DECODE, LOAD_A, LOAD_B, WRITE, HALT. One instruction = 5 cycles (FETCH..WRITE).
- IDLE:
  - start=1: pc <= start_pc; mode = run; -> FETCH.
  - Otherwise step=1: mode = single; -> FETCH.
  - start has priority over step.
- FETCH: instr_rd=1, instr_addr=pc -> DECODE.
- DECODE: latch {A,B,C} from instr_rdata; data_rd=1, data_addr=A -> LOAD_A.
- LOAD_A: op_a <= data_rdata; data_rd=1, data_addr=B -> LOAD_B.
- LOAD_B: temp <= data_rdata - op_a, mod 2^DATA_WIDTH, wrap, no overflow flag -> WRITE.
- WRITE:
  - data_wr=1, data_addr=B, data_wdata=temp.
  - leq = temp[MSB] | (temp==0).
  - pc <= leq ? C : pc+1, wrapping at 2^ADDR_WIDTH.
- Next state after WRITE, in priority order:
  - leq and C==pc (jump-to-self) -> HALT; pc = C.
  - stop_req or mode single -> IDLE.
  - Otherwise -> FETCH.
- stop_req: set by stop=1 in any busy state; cleared on entering IDLE or HALT. stop in IDLE is ignored.
- HALT: start=1 -> reload start_pc, -> FETCH run mode; step and stop ignored.
- Strobes are single-cycle and mutually exclusive; data_rd and data_wr are never high together.
- Self-modifying code is legal: the write in WRITE precedes the next FETCH.
- A==B is legal: result is 0, branch taken.
- Reset mid-instruction: aborts immediately, no write is issued on the reset cycle, state returns to IDLE.

Optional Feature:
- Macro SUBLEQ_RETIRE_CNT_EN.
- Defined: extra output retired_cnt, out, 32 bits. Cleared on reset and on accepted start; +1 in every WRITE cycle, including the halting one; wraps at 2^32.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Basic subtract-and-branch:
  - Stimulus: mem[10]=5, mem[11]=3, instr[0]={10,11,4}, start_pc=0, start pulse.
  - Response: 5 cycles later data_wr, addr 11, wdata 0xFFFFFFFE; pc=4.
- Not-taken branch:
  - Stimulus: mem[10]=2, mem[11]=7, instr[0]={10,11,9}.
  - Response: write 5 to addr 11; pc=1.
- Self-loop halt:
  - Stimulus: instr[1]={12,12,1}, start_pc=1.
  - Response: write 0 to addr 12; halted=1, busy=0, pc=1; later step pulse has no effect.
- Single step:
  - Stimulus: step in IDLE with pc=0, program of two non-halting instructions.
  - Response: exactly one data_wr, return to IDLE with pc updated; second step executes instruction 2.
- Stop and reset mid-run:
  - Stimulus: stop pulse during LOAD_A of an infinite loop; separately, rst=0 during LOAD_B.
  - Response: stop case finishes the current write, then IDLE, busy=0. Reset case: no data_wr, IDLE, pc=0.
- Wrap and counter:
  - Stimulus: ADDR_WIDTH=8, not-taken at pc=255; SUBLEQ_RETIRE_CNT_EN defined.
  - Response: pc=0; retired_cnt increments once per instruction, 0 after start.

Source files
------------

// File: rtl/subleq_exec_unit.sv
// SUBLEQ execution unit: mem[B] -= mem[A], branch to C when the result is <= 0.
// Optional retire counter output enabled by defining SUBLEQ_RETIRE_CNT_EN.
module subleq_exec_unit #(
  parameter  int ADDR_WIDTH  = 16,
  parameter  int DATA_WIDTH  = 32,
  localparam int INSTR_WIDTH = 3 * ADDR_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   step,
  input  logic                   stop,
  input  logic [ADDR_WIDTH-1:0]  start_pc,
  output logic                   instr_rd,
  output logic [ADDR_WIDTH-1:0]  instr_addr,
  input  logic [INSTR_WIDTH-1:0] instr_rdata,
  output logic                   data_rd,
  output logic                   data_wr,
  output logic [ADDR_WIDTH-1:0]  data_addr,
  output logic [DATA_WIDTH-1:0]  data_wdata,
  input  logic [DATA_WIDTH-1:0]  data_rdata,
  output logic                   busy,
  output logic                   halted,
  output logic [ADDR_WIDTH-1:0]  pc
`ifdef SUBLEQ_RETIRE_CNT_EN
  ,
  output logic [31:0]            retired_cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    LOAD_A,
    LOAD_B,
    WRITE,
    HALT
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] b_reg;
  logic [ADDR_WIDTH-1:0] c_reg;
  logic [DATA_WIDTH-1:0] op_a;
  logic [DATA_WIDTH-1:0] temp;
  logic                  stop_req;
  logic                  single_mode;

  logic [ADDR_WIDTH-1:0] field_a;
  logic [ADDR_WIDTH-1:0] field_b;
  logic [ADDR_WIDTH-1:0] field_c;
  logic                  leq;
  logic                  self_jump;
  logic                  start_ok;

  assign field_a   = instr_rdata[INSTR_WIDTH-1 -: ADDR_WIDTH];
  assign field_b   = instr_rdata[2*ADDR_WIDTH-1 -: ADDR_WIDTH];
  assign field_c   = instr_rdata[ADDR_WIDTH-1:0];
  assign leq       = temp[DATA_WIDTH-1] | (temp == '0);
  assign self_jump = leq && (c_reg == pc);
  assign busy      = (state != IDLE) && (state != HALT);
  assign halted    = (state == HALT);
  assign start_ok  = ((state == IDLE) || (state == HALT)) && start;

  // Strobes are gated by rst so a reset cycle never issues a memory access.
  always_comb begin
    state_next = state;
    instr_rd   = 1'b0;
    instr_addr = '0;
    data_rd    = 1'b0;
    data_wr    = 1'b0;
    data_addr  = '0;
    data_wdata = '0;
    case (state)
      IDLE: begin
        if (start || step) state_next = FETCH;
      end
      FETCH: begin
        instr_rd   = rst;
        instr_addr = pc;
        state_next = DECODE;
      end
      DECODE: begin
        data_rd    = rst;
        data_addr  = field_a;
        state_next = LOAD_A;
      end
      LOAD_A: begin
        data_rd    = rst;
        data_addr  = b_reg;
        state_next = LOAD_B;
      end
      LOAD_B: begin
        state_next = WRITE;
      end
      WRITE: begin
        data_wr    = rst;
        data_addr  = b_reg;
        data_wdata = temp;
        if (self_jump)                          state_next = HALT;
        else if (stop_req || stop || single_mode) state_next = IDLE;
        else                                    state_next = FETCH;
      end
      HALT: begin
        if (start) state_next = FETCH;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      pc          <= '0;
      b_reg       <= '0;
      c_reg       <= '0;
      op_a        <= '0;
      temp        <= '0;
      stop_req    <= 1'b0;
      single_mode <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (start) begin
            pc          <= start_pc;
            single_mode <= 1'b0;
          end else if (step) begin
            single_mode <= 1'b1;
          end
        end
        DECODE: begin
          b_reg <= field_b;
          c_reg <= field_c;
        end
        LOAD_A: op_a <= data_rdata;
        LOAD_B: temp <= data_rdata - op_a;
        WRITE:  pc   <= leq ? c_reg : pc + ADDR_WIDTH'(1);
        HALT: begin
          if (start) begin
            pc          <= start_pc;
            single_mode <= 1'b0;
          end
        end
        default: ;
      endcase
      // A stop seen while busy is held until the instruction retires.
      if ((state_next == IDLE) || (state_next == HALT)) stop_req <= 1'b0;
      else if (busy && stop)                            stop_req <= 1'b1;
    end
  end

`ifdef SUBLEQ_RETIRE_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst)                 retired_cnt <= '0;
    else if (start_ok)        retired_cnt <= '0;
    else if (state == WRITE)  retired_cnt <= retired_cnt + 32'd1;
  end
`else
  logic unused_start_ok;
  assign unused_start_ok = start_ok;
`endif

endmodule

// File: tb/tb_subleq_exec_unit.sv
// Self-checking bench for subleq_exec_unit (ADDR_WIDTH=8) against an ISA-level model.
// Retire-counter checks are included when SUBLEQ_RETIRE_CNT_EN is defined.
module tb_subleq_exec_unit;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int IW = 3 * AW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          step = 1'b0;
  logic          stop = 1'b0;
  logic [AW-1:0] start_pc = '0;
  logic          instr_rd;
  logic [AW-1:0] instr_addr;
  logic [IW-1:0] instr_rdata = '0;
  logic          data_rd;
  logic          data_wr;
  logic [AW-1:0] data_addr;
  logic [DW-1:0] data_wdata;
  logic [DW-1:0] data_rdata = '0;
  logic          busy;
  logic          halted;
  logic [AW-1:0] pc;
`ifdef SUBLEQ_RETIRE_CNT_EN
  logic [31:0]   retired_cnt;
`endif

  logic [IW-1:0] imem     [256];
  logic [DW-1:0] dmem     [256];
  logic [DW-1:0] ref_dmem [256];

  int            vectors = 0;
  int            miscompares = 0;
  logic [AW-1:0] m_pc = '0;
  logic          m_halt = 1'b0;
  logic [31:0]   m_ret = '0;

  subleq_exec_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .step(step), .stop(stop),
    .start_pc(start_pc), .instr_rd(instr_rd), .instr_addr(instr_addr),
    .instr_rdata(instr_rdata), .data_rd(data_rd), .data_wr(data_wr),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
    .busy(busy), .halted(halted), .pc(pc)
`ifdef SUBLEQ_RETIRE_CNT_EN
    , .retired_cnt(retired_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous-read Harvard memories with one-cycle latency.
  always @(posedge clk) begin
    if (instr_rd) instr_rdata <= imem[instr_addr];
    if (data_rd)  data_rdata  <= dmem[data_addr];
    if (data_wr)  dmem[data_addr] <= data_wdata;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic st, input logic sp, input logic [AW-1:0] spc);
    start = s; step = st; stop = sp; start_pc = spc;
    if (s) begin
      m_pc = spc; m_halt = 1'b0; m_ret = '0;
    end
    @(negedge clk);
    start = 1'b0; step = 1'b0; stop = 1'b0;
  endtask

  task automatic set_data(input logic [AW-1:0] a, input logic [DW-1:0] v);
    dmem[a] = v;
    ref_dmem[a] = v;
  endtask

  // Architectural model: one SUBLEQ instruction at m_pc.
  task automatic model_exec(output logic [AW-1:0] eb, output logic [DW-1:0] ew);
    logic [AW-1:0] a, c;
    logic          le;
    {a, eb, c} = imem[m_pc];
    ew = ref_dmem[eb] - ref_dmem[a];
    ref_dmem[eb] = ew;
    le = ($signed(ew) <= 0);
    m_halt = le && (c == m_pc);
    m_pc = le ? c : m_pc + 8'd1;
  endtask

  task automatic watch_run(input int budget, output int nwr, output int first_lat, output logic [DW-1:0] first_w);
    bit            pend = 0;
    bit            done = 0;
    logic [AW-1:0] eb;
    logic [DW-1:0] ew;
    nwr = 0; first_lat = -1; first_w = '0;
    for (int i = 0; i < budget && !done; i++) begin
      if (pend) begin
        checkOutput("pc_after_write", pc, m_pc);
`ifdef SUBLEQ_RETIRE_CNT_EN
        checkOutput("retired_cnt", retired_cnt, m_ret);
`endif
        pend = 0;
      end
      checkOutput("rd_wr_exclusive", data_rd & data_wr, 0);
      if (data_wr) begin
        model_exec(eb, ew);
        checkOutput("wr_addr", data_addr, eb);
        checkOutput("wr_data", data_wdata, ew);
        if (nwr == 0) begin
          first_lat = i + 1;
          first_w = data_wdata;
        end
        nwr++;
        m_ret++;
        pend = 1;
      end else if (!busy) begin
        done = 1;
      end
      if (!done) @(negedge clk);
    end
    checkOutput("watch_timeout", done, 1);
    checkOutput("halted_state", halted, m_halt);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    m_pc = '0; m_halt = 1'b0; m_ret = '0;
  endtask

  initial begin
    int            nwr, lat;
    logic [DW-1:0] fw;
    logic [DW-1:0] r;
    logic [AW-1:0] ra, rb, rc;

    for (int i = 0; i < 256; i++) begin
      imem[i] = '0;
      dmem[i] = '0;
      ref_dmem[i] = '0;
    end

    @(negedge clk);
    do_reset();
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_halted", halted, 0);
    checkOutput("reset_pc", pc, 0);
    checkOutput("reset_strobes", {instr_rd, data_rd, data_wr}, 0);
`ifdef SUBLEQ_RETIRE_CNT_EN
    checkOutput("reset_retired", retired_cnt, 0);
`endif

    $display("[TB] basic subtract-and-branch");
    set_data(8'd10, 32'd5); set_data(8'd11, 32'd3);
    imem[0] = {8'd10, 8'd11, 8'd4};
    imem[4] = {8'd12, 8'd12, 8'd4};
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd0);
    watch_run(40, nwr, lat, fw);
    checkOutput("basic_latency", lat, 5);
    checkOutput("basic_wdata", fw, 32'hFFFF_FFFE);
    checkOutput("basic_nwr", nwr, 2);
    checkOutput("basic_halt_pc", pc, 8'd4);

    $display("[TB] not-taken branch then self-loop halt");
    set_data(8'd10, 32'd2); set_data(8'd11, 32'd7); set_data(8'd12, 32'd99);
    imem[0] = {8'd10, 8'd11, 8'd9};
    imem[1] = {8'd12, 8'd12, 8'd1};
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd0);
    watch_run(40, nwr, lat, fw);
    checkOutput("nt_wdata", fw, 32'd5);
    checkOutput("halt_mem12", dmem[12], 0);
    checkOutput("halt_halted", halted, 1);
    checkOutput("halt_busy", busy, 0);
    checkOutput("halt_pc", pc, 8'd1);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'd0);
    repeat (3) begin
      checkOutput("halt_step_ignored", {halted, busy, instr_rd, data_wr}, 4'b1000);
      @(negedge clk);
    end
    checkOutput("halt_step_pc", pc, 8'd1);

    $display("[TB] single step");
    do_reset();
    r = $urandom_range(0, 1000);
    set_data(8'd20, r); set_data(8'd21, r + $urandom_range(1, 1000));
    set_data(8'd22, $urandom); set_data(8'd23, $urandom);
    imem[0] = {8'd20, 8'd21, 8'd7};
    imem[1] = {8'd22, 8'd23, 8'd9};
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd0);
    watch_run(20, nwr, lat, fw);
    checkOutput("step1_nwr", nwr, 1);
    checkOutput("step1_busy", busy, 0);
    checkOutput("step1_pc", pc, 8'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd0);
    watch_run(20, nwr, lat, fw);
    checkOutput("step2_nwr", nwr, 1);
    checkOutput("step2_busy", busy, 0);

    $display("[TB] stop mid-run");
    set_data(8'd15, 32'd0); set_data(8'd16, 32'd7); set_data(8'd17, $urandom);
    imem[20] = {8'd15, 8'd16, 8'd21};
    imem[21] = {8'd17, 8'd17, 8'd20};
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd20);
    repeat (2) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    watch_run(20, nwr, lat, fw);
    checkOutput("stop_nwr", nwr, 1);
    checkOutput("stop_busy", busy, 0);
    checkOutput("stop_pc", pc, 8'd21);

    $display("[TB] reset mid-run");
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd20);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checkOutput("rst_no_write", data_wr, 0);
    end
    rst = 1'b1;
    m_pc = '0; m_ret = '0; m_halt = 1'b0;
    @(negedge clk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_pc", pc, 0);

    $display("[TB] pc wrap");
    r = $urandom_range(0, 5000);
    set_data(8'd30, r); set_data(8'd31, r + $urandom_range(1, 5000));
    imem[255] = {8'd30, 8'd31, 8'd3};
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd255);
`ifdef SUBLEQ_RETIRE_CNT_EN
    checkOutput("wrap_retired_start", retired_cnt, 0);
`endif
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    watch_run(20, nwr, lat, fw);
    checkOutput("wrap_pc", pc, 8'd0);

    $display("[TB] randomized single steps");
    for (int k = 0; k < 10; k++) begin
      ra = 8'(32 + $urandom_range(0, 31));
      rb = (k % 4 == 0) ? ra : 8'(32 + $urandom_range(0, 31));
      rc = 8'($urandom_range(0, 255));
      if (rc == m_pc) rc = rc + 8'd1;
      set_data(ra, $urandom);
      if (rb != ra) set_data(rb, $urandom);
      imem[m_pc] = {ra, rb, rc};
      applyStimulus(1'b0, 1'b1, 1'b0, 8'd0);
      watch_run(20, nwr, lat, fw);
      checkOutput("rand_nwr", nwr, 1);
      checkOutput("rand_pc", pc, m_pc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
